// File: rtl/detector_sindrome_if.sv
// Word handshake between the receive path and the syndrome stage, and from the stage to the corrector.
// slave is the syndrome stage; master is the side that feeds words in and consumes the results.
interface detector_sindrome_if;
    logic [7:0] entrada;
    logic       valido_in;
    logic       listo_in;
    logic       listo_out;
    logic       valido_out;
    logic [7:0] recibido;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       st;
    logic       error_simple;
    logic       error_doble;

    modport slave (
        input  entrada, valido_in, listo_out,
        output listo_in, valido_out, recibido, s1, s2, s3, st, error_simple, error_doble
    );

    modport master (
        output entrada, valido_in, listo_out,
        input  listo_in, valido_out, recibido, s1, s2, s3, st, error_simple, error_doble
    );
endinterface

// File: rtl/detector_sindrome.sv
// Hamming(8,4) SECDED syndrome stage: classifies each word, keeps error counters and link health.
// 1-cycle latency; one-deep output register, listo_in = !valido_out || listo_out, output held while stalled.
module detector_sindrome #(
    parameter int UMBRAL = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   reloj,
    input  logic                   rst_n,
    input  logic                   limpiar,
    detector_sindrome_if.slave     bus,
    output logic [CNT_W-1:0]       cnt_simple,
    output logic [CNT_W-1:0]       cnt_doble,
    output logic [1:0]             estado
);
    typedef enum logic [1:0] {
        SANO      = 2'd0,
        DEGRADADO = 2'd1,
        FALLA     = 2'd2
    } estado_t;

    localparam logic [3:0]       UMBRAL_L = 4'(UMBRAL);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [7:0] e;
    logic       s1_c, s2_c, s3_c, st_c;
    logic       simple_c, doble_c;
    logic       fire;

    estado_t    est_q, est_d;
    logic [3:0] run_q, run_d;
    logic [3:0] run_inc;

    assign e    = bus.entrada;
    assign s1_c = ^{e[0], e[2], e[4], e[6]};
    assign s2_c = ^{e[1], e[2], e[5], e[6]};
    assign s3_c = ^{e[3], e[4], e[5], e[6]};
    assign st_c = ^e;

    // Odd overall parity always means one flip (including p0); even parity with a non-zero syndrome means two.
    assign simple_c = st_c;
    assign doble_c  = !st_c && ({s3_c, s2_c, s1_c} != 3'b000);

    assign bus.listo_in = !bus.valido_out || bus.listo_out;
    assign fire         = bus.valido_in && bus.listo_in;

    always_ff @(posedge reloj) begin
        if (!rst_n) begin
            bus.valido_out   <= 1'b0;
            bus.recibido     <= 8'h00;
            bus.s1           <= 1'b0;
            bus.s2           <= 1'b0;
            bus.s3           <= 1'b0;
            bus.st           <= 1'b0;
            bus.error_simple <= 1'b0;
            bus.error_doble  <= 1'b0;
        end else if (fire) begin
            bus.valido_out   <= 1'b1;
            bus.recibido     <= e;
            bus.s1           <= s1_c;
            bus.s2           <= s2_c;
            bus.s3           <= s3_c;
            bus.st           <= st_c;
            bus.error_simple <= simple_c;
            bus.error_doble  <= doble_c;
        end else if (bus.listo_out) begin
            bus.valido_out   <= 1'b0;
        end
    end

    always_ff @(posedge reloj) begin
        if (!rst_n || limpiar) begin
            cnt_simple <= '0;
            cnt_doble  <= '0;
        end else if (fire) begin
            if (simple_c && cnt_simple != CNT_MAX) cnt_simple <= cnt_simple + 1'b1;
            if (doble_c && cnt_doble != CNT_MAX)   cnt_doble  <= cnt_doble + 1'b1;
        end
    end

    always_ff @(posedge reloj) begin
        if (!rst_n) begin
            est_q <= SANO;
            run_q <= 4'd0;
        end else begin
            est_q <= est_d;
            run_q <= run_d;
        end
    end

    assign run_inc = run_q + 4'd1;

    // The run counter tracks consecutive words pulling toward the other health state.
    always_comb begin
        est_d = est_q;
        run_d = run_q;
        if (limpiar) begin
            est_d = SANO;
            run_d = 4'd0;
        end else if (fire) begin
            unique case (est_q)
                SANO: begin
                    if (doble_c) begin
                        est_d = FALLA;
                        run_d = 4'd0;
                    end else if (simple_c) begin
                        if (run_inc == UMBRAL_L) begin
                            est_d = DEGRADADO;
                            run_d = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                DEGRADADO: begin
                    if (doble_c) begin
                        est_d = FALLA;
                        run_d = 4'd0;
                    end else if (!simple_c) begin
                        if (run_inc == UMBRAL_L) begin
                            est_d = SANO;
                            run_d = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                FALLA: begin
                    est_d = FALLA;
                end
                default: begin
                    est_d = SANO;
                    run_d = 4'd0;
                end
            endcase
        end
    end

    assign estado = est_q;
endmodule

// File: tb/tb_detector_sindrome.sv
// Directed and randomized bench for detector_sindrome against a reference model in Hamming position arithmetic.
module tb_detector_sindrome;
    localparam int UMBRAL = 4;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             reloj = 1'b0;
    logic             rst_n;
    logic             limpiar;
    logic [CNT_W-1:0] cnt_simple;
    logic [CNT_W-1:0] cnt_doble;
    logic [1:0]       estado;

    detector_sindrome_if bus();

    detector_sindrome #(.UMBRAL(UMBRAL), .CNT_W(CNT_W)) dut (
        .reloj      (reloj),
        .rst_n      (rst_n),
        .limpiar    (limpiar),
        .bus        (bus),
        .cnt_simple (cnt_simple),
        .cnt_doble  (cnt_doble),
        .estado     (estado)
    );

    always #5 reloj = ~reloj;

    int n_total  = 0;
    int n_passed = 0;

    // Reference model state
    bit       m_vld;
    bit [7:0] m_word;
    bit [2:0] m_syn;
    bit       m_st, m_simple, m_doble;
    int       m_cs, m_cd, m_health, m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Syndrome as XOR of the 1-based positions of every set bit among bits 0..6.
    function automatic void classify(input bit [7:0] w, output bit [2:0] syn, output bit par);
        syn = 3'b000;
        for (int p = 1; p <= 7; p++)
            if (w[p-1]) syn ^= 3'(p);
        par = ($countones(w) % 2) == 1;
    endfunction

    task automatic check_outputs(input string ctx);
        chk({ctx, ".valido_out"},   32'(bus.valido_out),   32'(m_vld));
        chk({ctx, ".recibido"},     32'(bus.recibido),     32'(m_word));
        chk({ctx, ".s1"},           32'(bus.s1),           32'(m_syn[0]));
        chk({ctx, ".s2"},           32'(bus.s2),           32'(m_syn[1]));
        chk({ctx, ".s3"},           32'(bus.s3),           32'(m_syn[2]));
        chk({ctx, ".st"},           32'(bus.st),           32'(m_st));
        chk({ctx, ".error_simple"}, 32'(bus.error_simple), 32'(m_simple));
        chk({ctx, ".error_doble"},  32'(bus.error_doble),  32'(m_doble));
        chk({ctx, ".cnt_simple"},   32'(cnt_simple),       32'(m_cs));
        chk({ctx, ".cnt_doble"},    32'(cnt_doble),        32'(m_cd));
        chk({ctx, ".estado"},       32'(estado),           32'(m_health));
    endtask

    task automatic do_reset(input string ctx);
        rst_n = 1'b0;
        @(posedge reloj);
        #1;
        m_vld = 0; m_word = 0; m_syn = 0; m_st = 0; m_simple = 0; m_doble = 0;
        m_cs = 0; m_cd = 0; m_health = 0; m_run = 0;
        check_outputs(ctx);
        rst_n = 1'b1;
    endtask

    task automatic cycle(input string ctx, input bit [7:0] w, input bit vin, input bit lout, input bit clr);
        bit       fire, par, simple, doble;
        bit [2:0] syn;
        bus.entrada   = w;
        bus.valido_in = vin;
        bus.listo_out = lout;
        limpiar       = clr;
        #1;
        chk({ctx, ".listo_in"}, 32'(bus.listo_in), 32'(!m_vld || lout));
        fire = vin && (!m_vld || lout);
        classify(w, syn, par);
        simple = par;
        doble  = !par && syn != 0;
        @(posedge reloj);
        if (fire) begin
            m_vld = 1; m_word = w; m_syn = syn; m_st = par; m_simple = simple; m_doble = doble;
        end else if (lout) begin
            m_vld = 0;
        end
        if (clr) begin
            m_cs = 0; m_cd = 0; m_health = 0; m_run = 0;
        end else if (fire) begin
            if (simple && m_cs < CMAX) m_cs++;
            if (doble && m_cd < CMAX)  m_cd++;
            case (m_health)
                0: if (doble) begin m_health = 2; m_run = 0; end
                   else if (simple) begin
                       m_run++;
                       if (m_run == UMBRAL) begin m_health = 1; m_run = 0; end
                   end else m_run = 0;
                1: if (doble) begin m_health = 2; m_run = 0; end
                   else if (!simple) begin
                       m_run++;
                       if (m_run == UMBRAL) begin m_health = 0; m_run = 0; end
                   end else m_run = 0;
                default: ;
            endcase
        end
        #1;
        check_outputs(ctx);
    endtask

    initial begin
        bit [7:0] pool [5];
        pool[0] = 8'h66; pool[1] = 8'h76; pool[2] = 8'hE6; pool[3] = 8'h77; pool[4] = 8'h00;
        rst_n = 1'b0; limpiar = 1'b0;
        bus.entrada = 8'h00; bus.valido_in = 1'b0; bus.listo_out = 1'b1;
        #2;
        do_reset("reset");
        cycle("idle_after_reset", 8'h00, 0, 1, 0);

        cycle("clean_66", 8'h66, 1, 1, 0);
        cycle("single_bit4", 8'h76, 1, 1, 0);
        cycle("single_p0", 8'hE6, 1, 1, 0);
        cycle("clean_reset_run", 8'h66, 1, 1, 0);
        cycle("double_77", 8'h77, 1, 1, 0);
        cycle("falla_sticky", 8'h66, 1, 1, 0);
        cycle("clear_idle", 8'h00, 0, 1, 1);

        for (int i = 0; i < 4; i++) cycle("degrade", 8'h76, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle("restore_a", 8'h66, 1, 1, 0);
        cycle("restore_break", 8'h76, 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle("restore_b", 8'h66, 1, 1, 0);

        cycle("bp_first", 8'h66, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle("bp_stall", 8'h76, 1, 0, 0);
        cycle("bp_release", 8'h76, 1, 1, 0);
        cycle("bp_drain", 8'h00, 0, 1, 0);
        cycle("bp_empty", 8'h00, 0, 1, 0);

        cycle("clear_with_fire", 8'h77, 1, 1, 1);
        cycle("after_clear", 8'h00, 0, 1, 0);

        for (int i = 0; i < 300; i++) cycle("saturate", 8'h76, 1, 1, 0);
        chk("saturated_cnt_simple", 32'(cnt_simple), 32'(CMAX));
        cycle("clear_sat", 8'h00, 0, 1, 1);

        for (int i = 0; i < 400; i++) begin
            bit [7:0] w;
            w = ($urandom_range(0, 1) == 0) ? 8'($urandom) : pool[$urandom_range(0, 4)];
            cycle("random", w, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0));
        end

        cycle("mid_load", 8'h77, 1, 1, 0);
        cycle("mid_hold", 8'h66, 1, 0, 0);
        bus.valido_in = 1'b1;
        do_reset("reset_mid_transfer");
        cycle("post_reset", 8'h00, 0, 1, 0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
